// File: rtl/osc_pkg.sv
// Shared encodings and constants for the float32 square-wave stimulus generator.
package osc_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_LOW  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_ARM  = ST_ARM,
    S_HIGH = ST_HIGH,
    S_LOW  = ST_LOW,
    S_DONE = ST_DONE
  } osc_state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

endpackage

// File: rtl/osc_lfsr16.sv
// 16-bit Fibonacci LFSR used to dither the two LSBs of emitted mantissas.
// Only instantiated when OSC_STIM_DITHER_EN is defined.
module osc_lfsr16
  import osc_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_load) begin
      lfsr_d = i_seed;
    end else if (i_step) begin
      lfsr_d = {lfsr_q[14:0], fb};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr_q <= i_seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_q = lfsr_q;

endmodule

// File: rtl/osc_stim_gen.sv
// Bounded float32 square-wave stimulus for oscillation-interlock self-test.
// Optional mantissa dither enabled by defining OSC_STIM_DITHER_EN.
//
// state | meaning
// IDLE  | drive idle level, wait for start
// ARM   | latch config, clear counters
// HIGH  | emit hi level once per divider tick
// LOW   | emit lo level once per divider tick, count cycles
// DONE  | pulse done, reload idle level
module osc_stim_gen
  import osc_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_level_hi,
  input  logic [31:0]      i_level_lo,
  input  logic [31:0]      i_idle_level,
  input  logic [CNT_W-1:0] i_half_period,
  input  logic [CNT_W-1:0] i_sample_div,
  input  logic [CNT_W-1:0] i_cycle_num,
  output logic [31:0]      o_data,
  output logic             o_data_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  osc_state_e       state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] half_q, half_d, div_q, div_d, ncyc_q, ncyc_d;

  logic             tick, emit, last_smp;
  logic [CNT_W-1:0] smp_nxt, cycle_nxt;
  logic [31:0]      dith_mask;

  assign tick      = (div_cnt_q == div_q - ONE);
  assign emit      = !i_abort && ((state_q == S_HIGH) || (state_q == S_LOW)) && tick;
  assign smp_nxt   = smp_cnt_q + ONE;
  assign cycle_nxt = cycle_cnt_q + ONE;
  assign last_smp  = (smp_nxt == half_q);

`ifdef OSC_STIM_DITHER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_load;

  assign lfsr_load = !i_abort && (state_q == S_ARM);

  osc_lfsr16 u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (lfsr_load),
    .i_seed (LFSR_SEED),
    .i_step (emit),
    .o_q    (lfsr_q)
  );

  assign dith_mask = {30'b0, lfsr_q[1:0]};
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign dith_mask   = FLOAT_ZERO;
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    div_cnt_d   = div_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    half_d      = half_q;
    div_d       = div_q;
    ncyc_d      = ncyc_q;

    if (i_abort) begin
      state_d = S_IDLE;
      data_d  = i_idle_level;
    end else begin
      case (state_q)
        S_IDLE: begin
          data_d    = i_idle_level;
          div_cnt_d = '0;
          if (i_start) state_d = S_ARM;
        end
        S_ARM: begin
          hi_d        = i_level_hi;
          lo_d        = i_level_lo;
          half_d      = (i_half_period == '0) ? ONE : i_half_period;
          div_d       = (i_sample_div == '0) ? ONE : i_sample_div;
          ncyc_d      = i_cycle_num;
          div_cnt_d   = '0;
          smp_cnt_d   = '0;
          cycle_cnt_d = '0;
          state_d     = (i_cycle_num == '0) ? S_DONE : S_HIGH;
        end
        S_HIGH, S_LOW: begin
          // divider free-runs across HIGH/LOW so there is no phase gap
          div_cnt_d = tick ? '0 : div_cnt_q + ONE;
          if (emit) begin
            valid_d   = 1'b1;
            smp_cnt_d = last_smp ? '0 : smp_nxt;
            if (state_q == S_HIGH) begin
              data_d = hi_q ^ dith_mask;
              if (last_smp) state_d = S_LOW;
            end else begin
              data_d = lo_q ^ dith_mask;
              if (last_smp) begin
                cycle_cnt_d = cycle_nxt;
                state_d     = (cycle_nxt == ncyc_q) ? S_DONE : S_HIGH;
              end
            end
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          data_d  = i_idle_level;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      data_q      <= FLOAT_ZERO;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      div_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      hi_q        <= FLOAT_ZERO;
      lo_q        <= FLOAT_ZERO;
      half_q      <= '0;
      div_q       <= '0;
      ncyc_q      <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      div_cnt_q   <= div_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      half_q      <= half_d;
      div_q       <= div_d;
      ncyc_q      <= ncyc_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_done       = done_q;
  assign o_state      = state_q;
  assign o_cycle_cnt  = cycle_cnt_q;
  assign o_busy       = (state_q == S_ARM) || (state_q == S_HIGH) || (state_q == S_LOW);

endmodule

// File: tb/tb_osc_stim_gen.sv
// Scoreboard bench for osc_stim_gen: expected samples queued at start, checked per strobe.
module tb_osc_stim_gen;

  localparam int CNT_W = 32;
  localparam logic [31:0] IDLE_LVL = 32'h3F80_0000;
  localparam logic [31:0] HI_A     = 32'h40A0_0000;
  localparam logic [31:0] LO_A     = 32'h4040_0000;
  localparam logic [31:0] HI_B     = 32'hC0A0_0000;

  logic             clk = 1'b0;
  logic             i_rst, i_start, i_abort;
  logic [31:0]      i_level_hi, i_level_lo, i_idle_level;
  logic [CNT_W-1:0] i_half_period, i_sample_div, i_cycle_num;
  logic [31:0]      o_data;
  logic             o_data_valid, o_busy, o_done;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_cycle_cnt;

  always #5 clk = ~clk;

  osc_stim_gen #(.CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_level_hi    (i_level_hi),
    .i_level_lo    (i_level_lo),
    .i_idle_level  (i_idle_level),
    .i_half_period (i_half_period),
    .i_sample_div  (i_sample_div),
    .i_cycle_num   (i_cycle_num),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_state       (o_state),
    .o_cycle_cnt   (o_cycle_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  int cyc = 0;
  int n_strobe = 0, n_done = 0, last_vcyc = 0, done_cyc = 0;
  int base_strobe = 0, start_cyc = 0, exp_div = 1, exp_n = 0, exp_ncyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [31:0] e;
    if (o_data_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_strobe", 64'(o_data_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sample", 64'(o_data), 64'(e));
        if (n_strobe == base_strobe) chk("first_lat", 64'(cyc - start_cyc), 64'(1 + exp_div));
        else                         chk("gap", 64'(cyc - last_vcyc), 64'(exp_div));
      end
      n_strobe++;
      last_vcyc = cyc;
    end
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic start_burst(input logic [31:0] hi, input logic [31:0] lo,
                             input int half, input int div, input int ncyc);
    int eh;
    logic [31:0] lvl;
`ifdef OSC_STIM_DITHER_EN
    logic [15:0] lf;
    lf = 16'hACE1;
`endif
    eh = (half == 0) ? 1 : half;
    exp_div  = (div == 0) ? 1 : div;
    exp_n    = 2 * eh * ncyc;
    exp_ncyc = ncyc;
    i_level_hi    = hi;
    i_level_lo    = lo;
    i_half_period = CNT_W'(half);
    i_sample_div  = CNT_W'(div);
    i_cycle_num   = CNT_W'(ncyc);
    exp_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      for (int s = 0; s < 2 * eh; s++) begin
        lvl = (s < eh) ? hi : lo;
`ifdef OSC_STIM_DITHER_EN
        lvl[1:0] = lvl[1:0] ^ lf[1:0];
        lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`endif
        exp_q.push_back(lvl);
      end
    end
    base_strobe = n_strobe;
    i_start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    i_start = 1'b0;
    chk("arm_state", 64'(o_state), 64'd1);
    chk("arm_busy", 64'(o_busy), 64'd1);
    @(posedge clk); #1;
    chk("cnt_clear", 64'(o_cycle_cnt), 64'd0);
  endtask

  task automatic finish_burst();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (o_done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_seen", 64'(got), 64'd1);
    @(negedge clk); #1;
    chk("strobes", 64'(n_strobe - base_strobe), 64'(exp_n));
    if (exp_n > 0) chk("valid_to_done", 64'(done_cyc - last_vcyc), 64'd1);
    else           chk("start_to_done", 64'(done_cyc - start_cyc), 64'd2);
    chk("cycle_cnt", 64'(o_cycle_cnt), 64'(exp_ncyc));
    chk("idle_data", 64'(o_data), 64'(IDLE_LVL));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    chk("done_one_clk", 64'(o_done), 64'd0);
    chk("idle_state", 64'(o_state), 64'd0);
  endtask

  initial begin
    bit found;
    int nd0, ns0;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_level_hi = HI_A; i_level_lo = LO_A; i_idle_level = IDLE_LVL;
    i_half_period = '0; i_sample_div = '0; i_cycle_num = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_valid", 64'(o_data_valid), 64'd0);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_cnt", 64'(o_cycle_cnt), 64'd0);
    i_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_follow", 64'(o_data), 64'(IDLE_LVL));

    // basic burst
    start_burst(HI_A, LO_A, 4, 2, 3);
    finish_burst();

    // zero half/div treated as one
    start_burst(HI_A, LO_A, 0, 0, 2);
    finish_burst();

    // zero cycles
    start_burst(HI_A, LO_A, 4, 2, 0);
    finish_burst();

    // abort in LOW of second cycle, with start asserted the same clock
    start_burst(HI_A, LO_A, 4, 2, 3);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (o_state == 3'd3 && o_cycle_cnt == 1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_low2", 64'(found), 64'd1);
    nd0 = n_done;
    i_abort = 1'b1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    i_start = 1'b0;
    chk("abort_idle", 64'(o_state), 64'd0);
    chk("abort_valid", 64'(o_data_valid), 64'd0);
    exp_q.delete();
    ns0 = n_strobe;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_strobe", 64'(n_strobe - ns0), 64'd0);
    chk("abort_no_done", 64'(n_done - nd0), 64'd0);
    start_burst(HI_A, LO_A, 4, 2, 3);
    finish_burst();

    // config change during HIGH has no effect on the running burst
    start_burst(HI_A, LO_A, 4, 2, 3);
    chk("in_high", 64'(o_state), 64'd2);
    i_level_hi  = HI_B;
    i_cycle_num = 32'd5;
    finish_burst();
    start_burst(HI_B, LO_A, 4, 2, 3);
    finish_burst();

    // sync reset during HIGH
    start_burst(HI_A, LO_A, 4, 3, 2);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (o_state == 3'd2 && (n_strobe - base_strobe) >= 2) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_high", 64'(found), 64'd1);
    i_rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_data", 64'(o_data), 64'd0);
    chk("mrst_valid", 64'(o_data_valid), 64'd0);
    chk("mrst_busy", 64'(o_busy), 64'd0);
    chk("mrst_done", 64'(o_done), 64'd0);
    chk("mrst_state", 64'(o_state), 64'd0);
    chk("mrst_cnt", 64'(o_cycle_cnt), 64'd0);
    i_rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(o_data), 64'(IDLE_LVL));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
